// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral register port.
// Each transaction takes an ISSUE cycle and an ACK cycle. A short bus lock supports read-modify-write.
module periph_bus_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W/8-1:0]   m0_bwe,
  input  logic [DATA_W-1:0]     m0_din,
  output logic                  m0_ack,
  output logic [DATA_W-1:0]     m0_dout,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W/8-1:0]   m1_bwe,
  input  logic [DATA_W-1:0]     m1_din,
  output logic                  m1_ack,
  output logic [DATA_W-1:0]     m1_dout,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [DATA_W/8-1:0]   s_bwe,
  output logic [DATA_W-1:0]     s_din,
  input  logic [DATA_W-1:0]     s_dout,
  output logic [1:0]            gnt
);

  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;

  logic prev_served, arb_win, own_req, own_lock, oth_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // In ACK, last_q is only written at the edge, so the current owner is the most recently served master.
  always_comb begin
    prev_served = (state_q == ACK) ? owner_q : last_q;
    arb_win     = (m0_req && m1_req) ? ~prev_served : ~m0_req;
    own_req     = owner_q ? m1_req  : m0_req;
    own_lock    = owner_q ? m1_lock : m0_lock;
    oth_req     = owner_q ? m0_req  : m1_req;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d = arb_win;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = ACK;
      ACK: begin
        last_d = owner_q;
        if (own_lock && own_req && (!oth_req || lock_cnt_q < LOCK_MAX_C)) begin
          state_d = ISSUE;
          if (lock_cnt_q != 4'hF) lock_cnt_d = lock_cnt_q + 4'd1;
        end else begin
          lock_cnt_d = '0;
          if (m0_req || m1_req) begin
            owner_d = arb_win;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_addr  = '0;
    s_bwe   = '0;
    s_din   = '0;
    gnt     = 2'b00;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    m0_dout = '0;
    m1_dout = '0;
    if (state_q == ISSUE || state_q == ACK) begin
      s_addr = owner_q ? m1_addr : m0_addr;
      s_din  = owner_q ? m1_din  : m0_din;
      gnt    = owner_q ? 2'b10   : 2'b01;
    end
    if (state_q == ISSUE) begin
      s_bwe = owner_q ? m1_bwe : m0_bwe;
    end
    if (state_q == ACK) begin
      if (owner_q) begin
        m1_ack  = 1'b1;
        m1_dout = s_dout;
      end else begin
        m0_ack  = 1'b1;
        m0_dout = s_dout;
      end
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter. The peripheral model returns addr ^ 0x00A1 one cycle after the address.
module tb_periph_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_lock, m1_req, m1_lock;
  logic [15:0] m0_addr, m0_din, m1_addr, m1_din;
  logic [1:0]  m0_bwe, m1_bwe;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_dout, m1_dout;
  logic [15:0] s_addr, s_din, s_dout;
  logic [1:0]  s_bwe, gnt;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0, m0_ack_cnt = 0, m1_ack_cnt = 0;
  logic [15:0] wr_din;
  logic [1:0]  wr_bwe;

  periph_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_bwe(m0_bwe), .m0_din(m0_din),
    .m0_ack(m0_ack), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_bwe(m1_bwe), .m1_din(m1_din),
    .m1_ack(m1_ack), .m1_dout(m1_dout),
    .s_addr(s_addr), .s_bwe(s_bwe), .s_din(s_din), .s_dout(s_dout), .gnt(gnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) s_dout <= s_addr ^ 16'h00A1;

  always @(negedge clk) begin
    if (s_bwe != 2'b00) begin
      wr_cnt = wr_cnt + 1;
      wr_din = s_din;
      wr_bwe = s_bwe;
    end
    if (m0_ack) m0_ack_cnt = m0_ack_cnt + 1;
    if (m1_ack) m1_ack_cnt = m1_ack_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns positioned in the ack cycle; who=-1 on timeout, 2 if both acks.
  task automatic wait_ack(output int who, output int cycles);
    who = -1;
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cycles++;
      if (m0_ack && m1_ack) begin who = 2; return; end
      if (m0_ack) begin who = 0; return; end
      if (m1_ack) begin who = 1; return; end
    end
  endtask

  task automatic idle_masters();
    m0_req = 0; m0_lock = 0; m0_addr = '0; m0_bwe = '0; m0_din = '0;
    m1_req = 0; m1_lock = 0; m1_addr = '0; m1_bwe = '0; m1_din = '0;
  endtask

  task automatic apply_reset();
    idle_masters();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({gnt, m0_ack, m1_ack, s_bwe} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl: gnt=%b m0_ack=%b m1_ack=%b s_bwe=%b, expected all 0", gnt, m0_ack, m1_ack, s_bwe);
    end
    tests++;
    if ({s_addr, s_din, m0_dout, m1_dout} !== 64'h0) begin
      fails++; $display("FAIL reset_data: s_addr=%h s_din=%h m0_dout=%h m1_dout=%h, expected 0", s_addr, s_din, m0_dout, m1_dout);
    end
    tick(); tick(); tick();
    tests++;
    if (gnt !== 2'b00 || s_addr !== 16'h0) begin
      fails++; $display("FAIL idle_hold: gnt=%b s_addr=%h, expected 00/0000", gnt, s_addr);
    end
  endtask

  task automatic test_single_read();
    int m1_before;
    apply_reset();
    m1_before = m1_ack_cnt;
    m0_req = 1; m0_addr = 16'h0004; m0_bwe = 2'b00;
    tick();
    tests++;
    if (gnt !== 2'b01 || s_addr !== 16'h0004 || s_bwe !== 2'b00) begin
      fails++; $display("FAIL read_issue: gnt=%b s_addr=%h s_bwe=%b, expected 01/0004/00", gnt, s_addr, s_bwe);
    end
    tick();
    tests++;
    if (m0_ack !== 1'b1 || m0_dout !== 16'h00A5) begin
      fails++; $display("FAIL read_ack: m0_ack=%b m0_dout=%h, expected 1/00a5", m0_ack, m0_dout);
    end
    m0_req = 0;
    tick();
    tests++;
    if (m0_ack !== 1'b0 || gnt !== 2'b00) begin
      fails++; $display("FAIL read_done: m0_ack=%b gnt=%b, expected 0/00", m0_ack, gnt);
    end
    tick();
    tests++;
    if (m1_ack_cnt !== m1_before) begin
      fails++; $display("FAIL read_no_m1_ack: m1 acks=%0d, expected 0", m1_ack_cnt - m1_before);
    end
  endtask

  task automatic test_single_write();
    int wr_before, ack_before, who, cyc;
    apply_reset();
    wr_before = wr_cnt;
    ack_before = m1_ack_cnt;
    m1_req = 1; m1_addr = 16'h0002; m1_bwe = 2'b11; m1_din = 16'h1234;
    wait_ack(who, cyc);
    tests++;
    if (who !== 1 || cyc !== 2) begin
      fails++; $display("FAIL write_ack: who=%0d cycles=%0d, expected 1/2", who, cyc);
    end
    tests++;
    if (wr_cnt - wr_before !== 1 || wr_din !== 16'h1234 || wr_bwe !== 2'b11) begin
      fails++; $display("FAIL write_strobe: count=%0d din=%h bwe=%b, expected 1/1234/11", wr_cnt - wr_before, wr_din, wr_bwe);
    end
    tests++;
    if (s_bwe !== 2'b00) begin
      fails++; $display("FAIL write_bwe_in_ack: s_bwe=%b, expected 00", s_bwe);
    end
    m1_req = 0;
    tick(); tick(); tick();
    tests++;
    if (wr_cnt - wr_before !== 1 || m1_ack_cnt - ack_before !== 1) begin
      fails++; $display("FAIL write_once: writes=%0d acks=%0d, expected 1/1", wr_cnt - wr_before, m1_ack_cnt - ack_before);
    end
  endtask

  task automatic test_contention();
    int who, cyc;
    apply_reset();
    m0_req = 1; m0_addr = 16'h0010;
    m1_req = 1; m1_addr = 16'h0020;
    for (int i = 0; i < 6; i++) begin
      wait_ack(who, cyc);
      tests++;
      if (who !== (i % 2) || cyc !== 2) begin
        fails++; $display("FAIL contention_%0d: who=%0d cycles=%0d, expected %0d/2", i, who, cyc, i % 2);
      end
    end
    idle_masters();
    tick(); tick(); tick();
  endtask

  task automatic test_lock_cap();
    int who, cyc;
    int exp_who[7] = '{1, 1, 1, 1, 1, 0, 1};
    apply_reset();
    m1_req = 1; m1_lock = 1; m1_addr = 16'h0006;
    tick();
    m0_req = 1; m0_addr = 16'h000C;
    for (int i = 0; i < 7; i++) begin
      wait_ack(who, cyc);
      tests++;
      if (who !== exp_who[i]) begin
        fails++; $display("FAIL lock_cap_%0d: who=%0d, expected %0d", i, who, exp_who[i]);
      end
    end
    idle_masters();
    tick(); tick(); tick();
  endtask

  task automatic test_lock_no_contention();
    int who, cyc;
    int exp_cnt;
    apply_reset();
    m0_req = 1; m0_lock = 1; m0_addr = 16'h0008;
    for (int i = 0; i < 20; i++) begin
      wait_ack(who, cyc);
      exp_cnt = (i > 15) ? 15 : i;
      tests++;
      if (who !== 0 || cyc !== 2 || dut.lock_cnt_q !== 4'(exp_cnt)) begin
        fails++; $display("FAIL lock_solo_%0d: who=%0d cycles=%0d lock_cnt=%0d, expected 0/2/%0d", i, who, cyc, dut.lock_cnt_q, exp_cnt);
      end
    end
    idle_masters();
    tick(); tick();
    tests++;
    if (gnt !== 2'b00) begin
      fails++; $display("FAIL lock_solo_release: gnt=%b, expected 00", gnt);
    end
  endtask

  task automatic test_reset_mid_op();
    int who, cyc;
    apply_reset();
    m0_req = 1; m0_addr = 16'h0004;
    wait_ack(who, cyc);
    tests++;
    if (who !== 0) begin
      fails++; $display("FAIL midrst_pre: who=%0d, expected 0", who);
    end
    rst = 1;
    m0_req = 0;
    tick();
    tests++;
    if (m0_ack !== 1'b0 || gnt !== 2'b00 || s_bwe !== 2'b00) begin
      fails++; $display("FAIL midrst_abort: m0_ack=%b gnt=%b s_bwe=%b, expected 0/00/00", m0_ack, gnt, s_bwe);
    end
    rst = 0;
    m1_req = 1; m1_addr = 16'h0008;
    wait_ack(who, cyc);
    tests++;
    if (who !== 1 || cyc !== 2 || m1_dout !== 16'h00A9) begin
      fails++; $display("FAIL midrst_resume: who=%0d cycles=%0d m1_dout=%h, expected 1/2/00a9", who, cyc, m1_dout);
    end
    idle_masters();
    tick(); tick();
  endtask

  initial begin
    rst = 1;
    idle_masters();
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_lock_cap();
    test_lock_no_contention();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
